// File: rtl/crc_stream_unit.sv
// crc_stream_unit: streaming Galois-LFSR CRC over WCODE-bit words,
// BPC bits per clock, MSB first, chained across words until last.
module crc_stream_unit #(
  parameter int WCODE = 4,
  parameter int WPOLY = 5,
  parameter int BPC   = 1,
  parameter logic [WPOLY-2:0] INIT = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WPOLY-1:0] i_poly,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WCODE-1:0] i_data,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_ok
);

  localparam int R  = WPOLY - 1;
  localparam int N  = WCODE / BPC;
  localparam int CW = $clog2(N + 1);

  if ((BPC < 1) || ((WCODE % BPC) != 0)) begin : g_bpc_check
    $error("crc_stream_unit: BPC must divide WCODE");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [R-1:0]     crc_q, crc_d;
  logic [R-1:0]     poly_q, poly_d;
  logic [WCODE-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [R-1:0]     crc_nx;
  logic             fb;

  // The implicit x^R term never enters the register.
  logic unused_poly_msb;
  assign unused_poly_msb = i_poly[WPOLY-1];

  // BPC chained LFSR steps over the top bits of the latched word.
  always_comb begin
    crc_nx = crc_q;
    fb     = 1'b0;
    for (int j = 0; j < BPC; j++) begin
      fb     = crc_nx[R-1] ^ data_q[WCODE-1-j];
      crc_nx = {crc_nx[R-2:0], 1'b0} ^ (fb ? poly_q : '0);
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    poly_d  = poly_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) crc_d = INIT;
        if (i_valid) begin
          data_d  = i_data;
          last_d  = i_last;
          poly_d  = i_poly[R-1:0];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        crc_d  = crc_nx;
        data_d = data_q << BPC;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1))
          state_d = last_q ? DONE : IDLE;
      end
      DONE: begin
        o_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      poly_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      poly_q  <= poly_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_crc = crc_q;
  assign o_ok  = o_valid & (crc_q == '0);

endmodule
